// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sine/cosine engine: state encoding, gain,
// limits, Q-format helper and the arctangent table generator.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } cordic_state_e;

  localparam int  ITERS_MAX = 24;
  localparam int  CTR_W     = $clog2(ITERS_MAX + 1);
  localparam real CORDIC_K  = 0.6072529350;

  function automatic int q_one(input int out_w);
    return 1 << (out_w - 2);
  endfunction

  // atan(1/k) scaled by s, alternating series with integer terms
  function automatic logic [127:0] atan_inv(input logic [127:0] s, input logic [127:0] k);
    logic [127:0] pw;
    logic [127:0] sum;
    int           n;
    pw  = s / k;
    sum = 128'd0;
    n   = 0;
    while (pw != 128'd0) begin
      if ((n % 2) == 0) sum = sum + pw / 128'(2 * n + 1);
      else              sum = sum - pw / 128'(2 * n + 1);
      pw = pw / (k * k);
      n  = n + 1;
    end
    return sum;
  endfunction

  // round(atan(2^-i) / (2*pi) * 2^angle_w), integer-only so it folds at elaboration
  function automatic logic [63:0] atan_entry(input int angle_w, input int i);
    logic [127:0] s;
    logic [127:0] pi_s;
    logic [127:0] pw;
    logic [127:0] sum;
    logic [127:0] num;
    logic [127:0] den;
    int           n;
    s = 128'd1 << 80;
    if (i == 0) return 64'd1 << (angle_w - 3);
    pi_s = 128'd16 * atan_inv(s, 128'd5) - 128'd4 * atan_inv(s, 128'd239);
    sum  = 128'd0;
    pw   = s >> i;
    n    = 0;
    while (pw != 128'd0) begin
      if ((n % 2) == 0) sum = sum + pw / 128'(2 * n + 1);
      else              sum = sum - pw / 128'(2 * n + 1);
      pw = pw >> (2 * i);
      n  = n + 1;
    end
    num = sum << angle_w;
    den = pi_s << 1;
    return 64'(((num << 1) + den) / (den << 1));
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Constant arctangent table indexed by the iteration counter; zero past the last
// used iteration so a stray index never rotates the residual.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = 18,
  parameter int ITERS   = 16
) (
  input  logic [CTR_W-1:0]          idx,
  output logic signed [ANGLE_W:0]   atan_val
);

  logic signed [ANGLE_W:0] tab_s [ITERS_MAX];

  for (genvar g = 0; g < ITERS_MAX; g++) begin : g_tab
    if (g < ITERS) begin : g_used
      localparam logic [63:0] ENTRY = atan_entry(ANGLE_W, g);
      assign tab_s[g] = (ANGLE_W + 1)'(ENTRY);
    end else begin : g_zero
      assign tab_s[g] = '0;
    end
  end

  // table lookup with out-of-range guard
  always_comb begin
    if (idx < CTR_W'(ITERS_MAX)) atan_val = tab_s[idx];
    else                         atan_val = '0;
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC producing sine and cosine of a binary angle, with quadrant
// folding, rounding, saturation and valid/ready handshakes carrying a tag.
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = 18,
  parameter int OUT_W   = 16,
  parameter int GUARD   = 4,
  parameter int ITERS   = 16,
  parameter int TAG_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ANGLE_W-1:0]        in_angle,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_sin,
  output logic signed [OUT_W-1:0]   out_cos,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int XW  = OUT_W + GUARD + 1;
  localparam int ZW  = ANGLE_W + 1;
  localparam int ONE = q_one(OUT_W);
  localparam logic signed [XW-1:0]  X0    = XW'($rtoi(CORDIC_K * real'(64'd1 << (OUT_W - 2 + GUARD)) + 0.5));
  localparam logic signed [XW:0]    RND_W = (XW + 1)'(1 << (GUARD - 1));
  localparam logic signed [XW:0]    ONE_W = (XW + 1)'(ONE);
  localparam logic signed [OUT_W-1:0] ONE_O = OUT_W'(ONE);
  localparam logic [CTR_W-1:0]      LAST  = CTR_W'(ITERS - 1);

  cordic_state_e           state_r;
  logic [CTR_W-1:0]        ctr_r;
  logic [1:0]              q_r;
  logic signed [XW-1:0]    x_r, y_r;
  logic signed [ZW-1:0]    z_r;
  logic [TAG_W-1:0]        tag_r;

  logic signed [ZW-1:0]    atan_s;
  logic signed [XW-1:0]    xs_s, ys_s, x_nxt_s, y_nxt_s, fold_c_s, fold_s_s;
  logic signed [ZW-1:0]    z_nxt_s;
  logic                    accept_s;

  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [XW-1:0] v);
    logic signed [XW:0] r;
    r = ($signed({v[XW-1], v}) + RND_W) >>> GUARD;
    if (r > ONE_W)       return ONE_O;
    else if (r < -ONE_W) return -ONE_O;
    else                 return r[OUT_W-1:0];
  endfunction

  cordic_atan_rom #(
    .ANGLE_W (ANGLE_W),
    .ITERS   (ITERS)
  ) u_rom (
    .idx      (ctr_r),
    .atan_val (atan_s)
  );

  assign in_ready = reset_n && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  assign accept_s = in_valid && in_ready;

  // one micro-rotation, direction chosen by the sign of the residual
  always_comb begin
    xs_s = x_r >>> ctr_r;
    ys_s = y_r >>> ctr_r;
    if (z_r[ZW-1]) begin
      x_nxt_s = x_r + ys_s;
      y_nxt_s = y_r - xs_s;
      z_nxt_s = z_r + atan_s;
    end else begin
      x_nxt_s = x_r - ys_s;
      y_nxt_s = y_r + xs_s;
      z_nxt_s = z_r - atan_s;
    end
  end

  // map the first-quadrant vector back to the requested quadrant
  always_comb begin
    fold_c_s = x_r;
    fold_s_s = y_r;
    case (q_r)
      2'd0: begin fold_c_s = x_r;  fold_s_s = y_r;  end
      2'd1: begin fold_c_s = -y_r; fold_s_s = x_r;  end
      2'd2: begin fold_c_s = -x_r; fold_s_s = -y_r; end
      2'd3: begin fold_c_s = y_r;  fold_s_s = -x_r; end
      default: begin fold_c_s = x_r; fold_s_s = y_r; end
    endcase
  end

  // control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      ctr_r     <= '0;
      q_r       <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      tag_r     <= '0;
      out_valid <= 1'b0;
      out_sin   <= '0;
      out_cos   <= '0;
      out_tag   <= '0;
    end else begin
      case (state_r)
        IDLE: state_r <= IDLE;
        ITER: begin
          x_r   <= x_nxt_s;
          y_r   <= y_nxt_s;
          z_r   <= z_nxt_s;
          ctr_r <= ctr_r + CTR_W'(1);
          if (ctr_r == LAST) state_r <= ROUND;
          else               state_r <= ITER;
        end
        ROUND: begin
          out_cos   <= round_sat(fold_c_s);
          out_sin   <= round_sat(fold_s_s);
          out_tag   <= tag_r;
          out_valid <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: state_r <= IDLE;
      endcase
      // a new request overrides the IDLE/DONE next-state chosen above
      if (accept_s) begin
        state_r <= ITER;
        ctr_r   <= '0;
        q_r     <= in_angle[ANGLE_W-1 -: 2];
        z_r     <= {3'b000, in_angle[ANGLE_W-3:0]};
        x_r     <= X0;
        y_r     <= '0;
        tag_r   <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: directed corner angles, handshake
// timing, backpressure, reset abort and a randomized sweep against real trig.
module tb_cordic_sincos;

  localparam int AW  = 18;
  localparam int OW  = 16;
  localparam int TW  = 4;
  localparam int IT  = 16;
  localparam int LAT = IT + 1;
  localparam int NRAND = 2000;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [AW-1:0]        in_angle = '0;
  logic [TW-1:0]        in_tag = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [OW-1:0] out_sin, out_cos;
  logic [TW-1:0]        out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_sincos #(
    .ANGLE_W (AW),
    .OUT_W   (OW),
    .GUARD   (4),
    .ITERS   (IT),
    .TAG_W   (TW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sin   (out_sin),
    .out_cos   (out_cos),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // ideal value of sin/cos of the binary angle, in Q2.14, rounded to nearest
  function automatic int ideal(input logic [AW-1:0] a, input bit want_sin);
    real th, v;
    th = 2.0 * 3.14159265358979323846 * real'(a) / real'(64'd1 << AW);
    v  = want_sin ? $sin(th) : $cos(th);
    v  = v * 16384.0;
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  task automatic chk_eq(input string name, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic chk_near(input string name, input int obs, input int exp);
    bit ok;
    ok = ((obs - exp) <= 2) && ((exp - obs) <= 2) && (obs <= 16384) && (obs >= -16384);
    n_tests++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/-2 within +/-16384", name, obs, exp);
    end
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [TW-1:0] t);
    int n;
    n = 0;
    in_valid = 1'b1; in_angle = a; in_tag = t;
    #1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk_eq("accept_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_eq("taken_clears_valid", out_valid, 0);
  endtask

  task automatic run_one(input string name, input logic [AW-1:0] a, input logic [TW-1:0] t,
                         input int exp_cos, input int exp_sin);
    int lat;
    send(a, t);
    wait_result(lat);
    chk_eq({name, "_latency"}, lat, LAT);
    chk_near({name, "_cos"}, out_cos, exp_cos);
    chk_near({name, "_sin"}, out_sin, exp_sin);
    chk_eq({name, "_tag"}, out_tag, t);
    take();
  endtask

  initial begin
    int lat, c, first, second;
    logic signed [OW-1:0] hs, hc;
    logic [TW-1:0] ht;
    bit stable, acc;
    logic [AW-1:0] qa[$];
    logic [TW-1:0] qt[$];
    logic [AW-1:0] ea;
    logic [TW-1:0] et;
    int sent, got, cyc;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_out_sin", out_sin, 0);
    chk_eq("rst_out_cos", out_cos, 0);
    chk_eq("rst_out_tag", out_tag, 0);
    chk_eq("rst_in_ready", in_ready, 0);
    reset_n = 1'b1;
    #1;
    chk_eq("idle_in_ready", in_ready, 1);

    // cardinal and diagonal angles
    run_one("a0",     18'h00000, 4'h1, 16384, 0);
    run_one("a90",    18'h10000, 4'h2, 0, 16384);
    run_one("a270",   18'h30000, 4'h3, 0, -16384);
    run_one("a45",    18'h08000, 4'h4, 11585, 11585);
    run_one("a_wrap", 18'h3FFFF, 4'h5, 16384, 0);
    run_one("a180",   18'h20000, 4'h6, -16384, 0);

    // backpressure: result held, busy requests ignored
    send(18'h04000, 4'h3);
    wait_result(lat);
    chk_eq("bp_latency", lat, LAT);
    hs = out_sin; hc = out_cos; ht = out_tag;
    chk_near("bp_cos", hc, ideal(18'h04000, 1'b0));
    chk_near("bp_sin", hs, ideal(18'h04000, 1'b1));
    in_valid = 1'b1; in_angle = 18'h2AAAA; in_tag = 4'hA;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      stable = out_valid && (out_sin === hs) && (out_cos === hc) && (out_tag === ht) && !in_ready;
      chk_eq("bp_hold_stable", stable, 1);
    end
    out_ready = 1'b1;
    #1;
    chk_eq("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk_eq("bp_release_valid_low", out_valid, 0);
    wait_result(lat);
    chk_eq("bp_next_latency", lat, LAT);
    chk_eq("bp_next_tag", out_tag, 4'hA);
    chk_near("bp_next_cos", out_cos, ideal(18'h2AAAA, 1'b0));
    chk_near("bp_next_sin", out_sin, ideal(18'h2AAAA, 1'b1));
    take();

    // streaming throughput with out_ready held high
    out_ready = 1'b1; in_valid = 1'b1; in_angle = 18'h15555; in_tag = 4'h7;
    c = 0; first = 0; second = 0;
    while (second == 0 && c < 100) begin
      @(posedge clk); #1; c++;
      if (out_valid && first == 0) first = c;
      else if (out_valid && second == 0) second = c;
    end
    in_valid = 1'b0;
    chk_eq("stream_first", first, LAT + 1);
    chk_eq("stream_period", second - first, IT + 2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_eq("stream_drained", out_valid, 0);

    // reset in the middle of iterating aborts without a result
    send(18'h12345, 4'h9);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk_eq("abort_out_valid", out_valid, 0);
    chk_eq("abort_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_eq("abort_hold_in_ready", in_ready, 0);
    reset_n = 1'b1;
    #1;
    chk_eq("abort_release_in_ready", in_ready, 1);
    c = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) c++;
    end
    chk_eq("abort_no_result", c, 0);
    run_one("post_rst", 18'h20000, 4'hC, -16384, 0);

    // random sweep with random backpressure
    sent = 0; got = 0; cyc = 0;
    in_angle = AW'($urandom); in_tag = TW'($urandom); in_valid = 1'b1;
    while (got < NRAND && cyc < 60000) begin
      out_ready = ($urandom_range(3, 0) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (qa.size() == 0) begin
          chk_eq("rnd_spurious_result", 1, 0);
        end else begin
          ea = qa.pop_front(); et = qt.pop_front();
          chk_near("rnd_cos", out_cos, ideal(ea, 1'b0));
          chk_near("rnd_sin", out_sin, ideal(ea, 1'b1));
          chk_eq("rnd_tag", out_tag, et);
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        qa.push_back(in_angle); qt.push_back(in_tag); sent++;
      end
      @(posedge clk); #1; cyc++;
      if (acc) begin
        if (sent < NRAND) begin
          in_angle = AW'($urandom); in_tag = TW'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    chk_eq("rnd_count", got, NRAND);
    chk_eq("rnd_sent", sent, NRAND);
    chk_eq("rnd_queue_empty", qa.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
